// File: rtl/serial_nand_adder_ctrl_if.sv
// Handshake bundle for the bit-serial adder controller: operand request side
// and result response side.
interface serial_nand_adder_ctrl_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             overflow;
    logic             busy;

    modport master (
        output in_valid, a, b, cin, out_ready,
        input  in_ready, out_valid, sum, cout, overflow, busy
    );

    modport slave (
        input  in_valid, a, b, cin, out_ready,
        output in_ready, out_valid, sum, cout, overflow, busy
    );
endinterface

// File: rtl/serial_nand_adder_ctrl.sv
// Bit-serial two's-complement adder: feeds one bit pair per clock (LSB first)
// through a NAND-level full-adder cell and returns sum, carry-out and overflow.
module serial_nand_fa (
    input  logic a,
    input  logic b,
    input  logic c,
    output logic s,
    output logic co
);
    logic n1, n2, n3, x, n4, n5, n6;

    assign n1 = ~(a & b);
    assign n2 = ~(a & n1);
    assign n3 = ~(b & n1);
    assign x  = ~(n2 & n3);
    assign n4 = ~(x & c);
    assign n5 = ~(x & n4);
    assign n6 = ~(c & n4);
    assign s  = ~(n5 & n6);
    assign co = ~(n4 & n1);
endmodule

module serial_nand_adder_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    serial_nand_adder_ctrl_if.slave bus
);
    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t           state, state_next;
    logic [WIDTH-1:0] a_sh, b_sh, sum_sh;
    logic [WIDTH-1:0] sum_q;
    logic             carry, cout_q, ovf_q;
    logic [CW-1:0]    count;
    logic             load, step, last;
    logic             fa_s, fa_co;

    serial_nand_fa u_fa (
        .a  (a_sh[0]),
        .b  (b_sh[0]),
        .c  (carry),
        .s  (fa_s),
        .co (fa_co)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        load       = 1'b0;
        step       = 1'b0;
        last       = 1'b0;
        case (state)
            IDLE: begin
                if (bus.in_valid) begin
                    load       = 1'b1;
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                step = 1'b1;
                if (count == CW'(WIDTH - 1)) begin
                    last       = 1'b1;
                    state_next = DONE;
                end
            end
            DONE: begin
                if (bus.out_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh   <= '0;
            b_sh   <= '0;
            sum_sh <= '0;
            carry  <= 1'b0;
            count  <= '0;
            sum_q  <= '0;
            cout_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else if (load) begin
            a_sh  <= bus.a;
            b_sh  <= bus.b;
            carry <= bus.cin;
            count <= '0;
        end else if (step) begin
            a_sh   <= {1'b0, a_sh[WIDTH-1:1]};
            b_sh   <= {1'b0, b_sh[WIDTH-1:1]};
            sum_sh <= {fa_s, sum_sh[WIDTH-1:1]};
            carry  <= fa_co;
            count  <= count + CW'(1);
            // carry still holds the carry into the MSB on the final bit
            if (last) begin
                sum_q  <= {fa_s, sum_sh[WIDTH-1:1]};
                cout_q <= fa_co;
                ovf_q  <= carry ^ fa_co;
            end
        end
    end

    assign bus.in_ready  = (state == IDLE);
    assign bus.out_valid = (state == DONE);
    assign bus.busy      = (state != IDLE);
    assign bus.sum       = sum_q;
    assign bus.cout      = cout_q;
    assign bus.overflow  = ovf_q;
endmodule

// File: tb/tb_serial_nand_adder_ctrl.sv
// Self-checking bench for serial_nand_adder_ctrl: directed corner cases plus
// randomized operations against a plain-arithmetic reference.
module tb_serial_nand_adder_ctrl;
    localparam int W = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_pass = 0;

    serial_nand_adder_ctrl_if #(.WIDTH(W)) ifc ();

    serial_nand_adder_ctrl #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifc.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    endtask

    // Reference result computed from the arithmetic definition.
    task automatic ref_add(input logic [W-1:0] av, input logic [W-1:0] bv, input logic ci,
                           output logic [W-1:0] es, output logic ec, output logic eo);
        logic [W:0] full;
        int         sres;
        full = {1'b0, av} + {1'b0, bv} + {{W{1'b0}}, ci};
        es   = full[W-1:0];
        ec   = full[W];
        sres = int'($signed(av)) + int'($signed(bv)) + int'(ci);
        eo   = (sres > (2 ** (W - 1)) - 1) || (sres < -(2 ** (W - 1)));
    endtask

    task automatic do_op(input logic [W-1:0] av, input logic [W-1:0] bv, input logic ci,
                         input int stall, input bit scramble);
        logic [W-1:0] es;
        logic         ec, eo;
        int           lat;
        ref_add(av, bv, ci, es, ec, eo);

        @(negedge clk);
        ifc.a         = av;
        ifc.b         = bv;
        ifc.cin       = ci;
        ifc.in_valid  = 1'b1;
        ifc.out_ready = (stall == 0);
        check("in_ready_idle", ifc.in_ready, 1);
        @(posedge clk); #1;
        ifc.in_valid = 1'b0;

        lat = 0;
        while (!ifc.out_valid && lat < 40) begin
            if (scramble) begin
                ifc.a        = W'($urandom);
                ifc.b        = W'($urandom);
                ifc.cin      = 1'($urandom);
                ifc.in_valid = 1'($urandom);
            end
            @(posedge clk); #1;
            lat++;
        end
        check("latency", lat, W);
        check("sum", ifc.sum, es);
        check("cout", ifc.cout, ec);
        check("overflow", ifc.overflow, eo);
        check("in_ready_done", ifc.in_ready, 0);
        check("busy_done", ifc.busy, 1);

        for (int s = 0; s < stall; s++) begin
            ifc.in_valid = 1'b1;
            ifc.a        = 8'hAA;
            @(posedge clk); #1;
            check("hold_valid", ifc.out_valid, 1);
            check("hold_sum", ifc.sum, es);
            check("hold_in_ready", ifc.in_ready, 0);
        end

        // in_valid high on the transfer edge must not start a new operation
        ifc.in_valid  = 1'b1;
        ifc.out_ready = 1'b1;
        @(posedge clk); #1;
        ifc.in_valid = 1'b0;
        check("xfer_valid_low", ifc.out_valid, 0);
        check("xfer_in_ready", ifc.in_ready, 1);
        check("xfer_busy", ifc.busy, 0);
        check("retain_sum", ifc.sum, es);
        check("retain_cout", ifc.cout, ec);
    endtask

    initial begin
        ifc.in_valid  = 1'b0;
        ifc.a         = '0;
        ifc.b         = '0;
        ifc.cin       = 1'b0;
        ifc.out_ready = 1'b1;

        #12;
        check("rst_sum", ifc.sum, 0);
        check("rst_valid", ifc.out_valid, 0);
        check("rst_busy", ifc.busy, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_in_ready", ifc.in_ready, 1);

        do_op(8'h05, 8'h03, 1'b0, 0, 1'b0);
        do_op(8'h7F, 8'h01, 1'b0, 0, 1'b0);
        do_op(8'h80, 8'h80, 1'b0, 0, 1'b0);
        do_op(8'hFF, 8'h00, 1'b1, 0, 1'b0);
        do_op(8'hFF, 8'hFF, 1'b1, 0, 1'b0);
        do_op(8'h12, 8'h34, 1'b0, 5, 1'b0);
        do_op(8'h5A, 8'h3C, 1'b1, 0, 1'b1);

        // Abort mid-SHIFT with an asynchronous reset; the previous sum is nonzero.
        @(negedge clk);
        ifc.a        = 8'h0F;
        ifc.b        = 8'h70;
        ifc.cin      = 1'b1;
        ifc.in_valid = 1'b1;
        @(posedge clk); #1;
        ifc.in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("abort_sum", ifc.sum, 0);
        check("abort_cout", ifc.cout, 0);
        check("abort_ovf", ifc.overflow, 0);
        check("abort_valid", ifc.out_valid, 0);
        check("abort_busy", ifc.busy, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("abort_in_ready", ifc.in_ready, 1);
        do_op(8'h01, 8'h01, 1'b0, 0, 1'b0);

        for (int i = 0; i < 20; i++) begin
            do_op(W'($urandom), W'($urandom), 1'($urandom), int'($urandom_range(0, 3)), 1'b1);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end
endmodule
